// File: rtl/fsk_rx_controller_if.sv
// Signal bundle between the FSK receive controller, its demodulator and the byte consumer.
// The slave modport is the controller's view; master is the environment driving it.
interface fsk_rx_controller_if;
    logic       start_i;
    logic       abort_i;
    logic       demod_rst_o;
    logic       demod_bit_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       data_ready_i;
    logic       busy_o;
    logic       frame_done_o;
    logic       timeout_o;
    logic       overrun_o;

    modport slave (
        input  start_i, abort_i, demod_bit_i, data_ready_i,
        output demod_rst_o, data_o, data_valid_o, busy_o, frame_done_o, timeout_o, overrun_o
    );

    modport master (
        output start_i, abort_i, demod_bit_i, data_ready_i,
        input  demod_rst_o, data_o, data_valid_o, busy_o, frame_done_o, timeout_o, overrun_o
    );
endinterface

// File: rtl/fsk_rx_controller.sv
// Receive-frame sequencer for the FSK demodulator: clear/align, slot timing recovery,
// sync-word hunt, MSB-first payload assembly and valid/ready byte delivery.
module fsk_rx_controller #(
    parameter int unsigned       SLOT_CLKS     = 16,
    parameter int unsigned       SYNC_W        = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD     = 8'hA5,
    parameter int unsigned       PAYLOAD_BYTES = 4,
    parameter int unsigned       HUNT_TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    fsk_rx_controller_if.slave bus
);
    localparam int unsigned SCW = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ALIGN   = 2'd1;
    localparam logic [1:0] ST_HUNT    = 2'd2;
    localparam logic [1:0] ST_PAYLOAD = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [SCW-1:0]    slot_cnt_q, slot_cnt_d;
    logic              first_q, first_d;
    logic [SYNC_W-1:0] sync_q, sync_d;
    logic [9:0]        hunt_cnt_q, hunt_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        data_q, data_d;
    logic              data_valid_q, data_valid_d;
    logic              demod_rst_q, demod_rst_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;

    logic              slot_done_s;
    logic [SYNC_W-1:0] sync_next_s;
    logic [7:0]        byte_next_s;

    // Slot boundary detection and the shifted-in candidates for sync and payload.
    always_comb begin
        slot_done_s = ((state_q == ST_HUNT) || (state_q == ST_PAYLOAD)) &&
                      (slot_cnt_q == '0) && !first_q;
        sync_next_s = {sync_q[SYNC_W-2:0], bus.demod_bit_i};
        byte_next_s = {byte_q[6:0], bus.demod_bit_i};
    end

    // Next-state logic for the frame sequencer and its outputs.
    always_comb begin
        state_d      = state_q;
        first_d      = 1'b0;
        sync_d       = sync_q;
        hunt_cnt_d   = hunt_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        byte_d       = byte_q;
        data_d       = data_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;

        if (state_q == ST_ALIGN) begin
            slot_cnt_d = '0;
        end else if (slot_cnt_q == SCW'(SLOT_CLKS - 1)) begin
            slot_cnt_d = '0;
        end else begin
            slot_cnt_d = slot_cnt_q + {{(SCW-1){1'b0}}, 1'b1};
        end

        // Acceptance retires the held byte; a newly completed byte below overrides this.
        if (data_valid_q && bus.data_ready_i) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end

        if (bus.abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_d    = ST_ALIGN;
                        overrun_d  = 1'b0;
                        sync_d     = '0;
                        byte_d     = 8'h00;
                        hunt_cnt_d = 10'd0;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ALIGN: begin
                    first_d = 1'b1;
                    state_d = ST_HUNT;
                end
                ST_HUNT: begin
                    if (slot_done_s) begin
                        sync_d     = sync_next_s;
                        hunt_cnt_d = hunt_cnt_q + 10'd1;
                        // A match on the last permitted slot takes priority over expiry.
                        if (sync_next_s == SYNC_WORD) begin
                            state_d    = ST_PAYLOAD;
                            bit_cnt_d  = 3'd0;
                            byte_cnt_d = 8'd0;
                        end else if (hunt_cnt_q + 10'd1 == 10'(HUNT_TIMEOUT)) begin
                            timeout_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_PAYLOAD: begin
                    if (slot_done_s) begin
                        byte_d    = byte_next_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (!data_valid_q || bus.data_ready_i) begin
                                data_d       = byte_next_s;
                                data_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                            byte_cnt_d = byte_cnt_q + 8'd1;
                            if (byte_cnt_q == 8'(PAYLOAD_BYTES - 1)) begin
                                frame_done_d = 1'b1;
                                state_d      = ST_IDLE;
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d      = (state_d != ST_IDLE);
        demod_rst_d = (state_d == ST_IDLE) || (state_d == ST_ALIGN);
    end

    // State and registered outputs, cleared asynchronously to their idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            slot_cnt_q   <= '0;
            first_q      <= 1'b0;
            sync_q       <= '0;
            hunt_cnt_q   <= 10'd0;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 8'd0;
            byte_q       <= 8'h00;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            demod_rst_q  <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            first_q      <= first_d;
            sync_q       <= sync_d;
            hunt_cnt_q   <= hunt_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            byte_q       <= byte_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            demod_rst_q  <= demod_rst_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.demod_rst_o  = demod_rst_q;
    assign bus.data_o       = data_q;
    assign bus.data_valid_o = data_valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.frame_done_o = frame_done_q;
    assign bus.timeout_o    = timeout_q;
    assign bus.overrun_o    = overrun_q;
endmodule

// File: tb/tb_fsk_rx_controller.sv
// Scoreboard bench for fsk_rx_controller: directed frames push expected bytes/events,
// an independent monitor pops and compares them as the DUT presents them.
module tb_fsk_rx_controller;
    logic clk;
    logic rst_n;
    int   cyc;
    int   c0;
    int   n_checks;
    int   n_pass;

    fsk_rx_controller_if bus ();

    fsk_rx_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] exp_q[$];
    logic [7:0] exp_fd_q[$];
    int         exp_to_q[$];
    bit         bitq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bitq.push_back(v[i]);
    endtask

    // Starts a frame and drives each queued bit only in the last clock before its slot sample,
    // with the complement elsewhere, so any sampling-phase error corrupts the data.
    task automatic run_frame();
        @(negedge clk);
        c0 = cyc;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("busy_after_start", bus.busy_o, 1'b1);
        chk("demod_rst_align", bus.demod_rst_o, 1'b1);
        chk("overrun_cleared", bus.overrun_o, 1'b0);
        @(negedge clk);
        chk("demod_rst_released", bus.demod_rst_o, 1'b0);
        @(negedge clk);
        while (bitq.size() > 0) begin
            bit b;
            b = bitq.pop_front();
            bus.demod_bit_i = ~b;
            repeat (15) @(negedge clk);
            bus.demod_bit_i = b;
            @(negedge clk);
        end
    endtask

    // Monitor: compares every accepted byte and every frame_done/timeout pulse with the scoreboard.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.data_valid_o && bus.data_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'h0, bus.data_o}, 32'hFFFF_FFFF);
                end else begin
                    chk("byte", {24'h0, bus.data_o}, {24'h0, exp_q.pop_front()});
                end
            end
            if (bus.frame_done_o) begin
                if (exp_fd_q.size() == 0) begin
                    chk("unexpected_frame_done", 32'd1, 32'd0);
                end else begin
                    chk("frame_done_data", {24'h0, bus.data_o}, {24'h0, exp_fd_q.pop_front()});
                    chk("frame_done_valid", bus.data_valid_o, 1'b1);
                end
            end
            if (bus.timeout_o) begin
                if (exp_to_q.size() == 0) begin
                    chk("unexpected_timeout", 32'd1, 32'd0);
                end else begin
                    chk("timeout_cycle", cyc, exp_to_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [12:0] noise;
        cyc = 0;
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.demod_bit_i = 1'b0;
        bus.data_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_demod_rst", bus.demod_rst_o, 1'b1);
        chk("rst_data", bus.data_o, 8'h00);
        chk("rst_data_valid", bus.data_valid_o, 1'b0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_frame_done", bus.frame_done_o, 1'b0);
        chk("rst_timeout", bus.timeout_o, 1'b0);
        chk("rst_overrun", bus.overrun_o, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean frame with the consumer always ready.
        bus.data_ready_i = 1'b1;
        add_byte(8'hA5); add_byte(8'h3C); add_byte(8'hC3); add_byte(8'h00); add_byte(8'hFF);
        exp_q.push_back(8'h3C); exp_q.push_back(8'hC3); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        exp_fd_q.push_back(8'hFF);
        run_frame();
        repeat (3) @(negedge clk);
        chk("clean_busy_end", bus.busy_o, 1'b0);
        chk("clean_overrun", bus.overrun_o, 1'b0);

        // Noise ending in a partial sync prefix; lock must come on the 21st slot.
        noise = 13'b0110110111010;
        for (int i = 12; i >= 0; i--) bitq.push_back(noise[i]);
        add_byte(8'hA5); add_byte(8'h5A); add_byte(8'h01); add_byte(8'h80); add_byte(8'h7E);
        exp_q.push_back(8'h5A); exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'h7E);
        exp_fd_q.push_back(8'h7E);
        run_frame();
        repeat (3) @(negedge clk);
        chk("noise_busy_end", bus.busy_o, 1'b0);

        // Hunt expiry on an all-zero stream.
        for (int i = 0; i < 64; i++) bitq.push_back(1'b0);
        fork
            run_frame();
            begin
                repeat (3) @(negedge clk);
                exp_to_q.push_back(c0 + 1027);
            end
        join
        chk("timeout_busy_drop", bus.busy_o, 1'b0);
        chk("timeout_demod_rst", bus.demod_rst_o, 1'b1);
        repeat (3) @(negedge clk);

        // Back-pressure: second byte dropped while the first is held.
        bus.data_ready_i = 1'b0;
        add_byte(8'hA5); add_byte(8'h12); add_byte(8'h34); add_byte(8'h56); add_byte(8'h78);
        exp_q.push_back(8'h12); exp_q.push_back(8'h56); exp_q.push_back(8'h78);
        exp_fd_q.push_back(8'h78);
        fork
            run_frame();
            begin
                repeat (400) @(negedge clk);
                chk("bp_held_valid", bus.data_valid_o, 1'b1);
                chk("bp_held_data", bus.data_o, 8'h12);
                chk("bp_overrun_set", bus.overrun_o, 1'b1);
                repeat (21) @(negedge clk);
                bus.data_ready_i = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        chk("bp_overrun_sticky", bus.overrun_o, 1'b1);

        // Abort in PAYLOAD with a byte pending; it must still drain.
        add_byte(8'hA5); add_byte(8'hDE); add_byte(8'hAD); add_byte(8'hBE);
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        fork
            run_frame();
            begin
                repeat (301) @(negedge clk);
                bus.data_ready_i = 1'b0;
                repeat (100) @(negedge clk);
                bus.abort_i = 1'b1;
                @(negedge clk);
                bus.abort_i = 1'b0;
                chk("abort_busy", bus.busy_o, 1'b0);
                chk("abort_demod_rst", bus.demod_rst_o, 1'b1);
                chk("abort_pending_valid", bus.data_valid_o, 1'b1);
                chk("abort_pending_data", bus.data_o, 8'hAD);
                repeat (19) @(negedge clk);
                bus.data_ready_i = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        chk("abort_drained", bus.data_valid_o, 1'b0);

        // Asynchronous reset while a byte is held in PAYLOAD.
        bus.data_ready_i = 1'b0;
        add_byte(8'hA5); add_byte(8'h11); add_byte(8'h22);
        fork
            run_frame();
            begin
                repeat (301) @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk("arst_demod_rst", bus.demod_rst_o, 1'b1);
                chk("arst_data_valid", bus.data_valid_o, 1'b0);
                chk("arst_busy", bus.busy_o, 1'b0);
                chk("arst_data", bus.data_o, 8'h00);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (2) @(negedge clk);
                chk("arst_idle_after_release", bus.busy_o, 1'b0);
            end
        join
        repeat (5) @(negedge clk);
        chk("arst_still_idle", bus.busy_o, 1'b0);

        chk("bytes_all_seen", exp_q.size(), 0);
        chk("frame_done_all_seen", exp_fd_q.size(), 0);
        chk("timeouts_all_seen", exp_to_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
